// File: rtl/reg_f_arb.sv
// Round-robin two-port arbiter for the single-port register file.
// Provides a REQ/GNT handshake, registered read data and write-protected constant registers 0/1.
module reg_f_arb #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned SIZE  = 11,
  parameter int unsigned SELW  = $clog2(SIZE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [SELW-1:0]  ADDR0,
  input  logic [SELW-1:0]  ADDR1,
  input  logic [WIDTH-1:0] WDATA0,
  input  logic [WIDTH-1:0] WDATA1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             RVALID0,
  output logic             RVALID1,
  output logic [WIDTH-1:0] RDATA,
  output logic             ERR,
  output logic [SELW-1:0]  RF_SEL,
  output logic [WIDTH-1:0] RF_IN,
  output logic             RF_EN,
  input  logic [WIDTH-1:0] RF_OUT
);

  localparam logic [SELW:0]   MAX_IDX = (SELW+1)'(SIZE);
  localparam logic [SELW-1:0] ONE_IDX = SELW'(1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e           state_q;
  logic             last_q;
  logic             win_q;
  logic             we_q;
  logic [1:0]       gnt_q;
  logic [1:0]       rvalid_q;
  logic             err_q;
  logic             rf_en_q;
  logic [SELW-1:0]  rf_sel_q;
  logic [WIDTH-1:0] rf_in_q;
  logic [WIDTH-1:0] rdata_q;

  logic             pick_vld;
  logic             pick;
  logic             pick_we;
  logic [SELW-1:0]  pick_addr;
  logic [WIDTH-1:0] pick_wdata;
  logic             pick_bad;
  logic [WIDTH-1:0] rd_val;

  always_comb begin
    pick_vld   = 1'b0;
    pick       = 1'b0;
    if (state_q == IDLE) begin
      pick_vld = REQ0 | REQ1;
      pick     = (REQ0 & REQ1) ? ~last_q : REQ1;
    end else begin
      // The port being served still holds REQ, so only the other one may follow.
      pick     = ~win_q;
      pick_vld = win_q ? REQ0 : REQ1;
    end
    pick_we    = pick ? WE1    : WE0;
    pick_addr  = pick ? ADDR1  : ADDR0;
    pick_wdata = pick ? WDATA1 : WDATA0;
    pick_bad   = ({1'b0, pick_addr} > MAX_IDX) | (pick_we & (pick_addr <= ONE_IDX));

    if (({1'b0, rf_sel_q} > MAX_IDX) || (rf_sel_q == '0)) begin
      rd_val = '0;
    end else if (rf_sel_q == ONE_IDX) begin
      rd_val = '1;
    end else begin
      rd_val = RF_OUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
      rf_en_q  <= 1'b0;
      rf_sel_q <= '0;
      rf_in_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (state_q == ACCESS) begin
        last_q <= win_q;
        if (!we_q) begin
          rdata_q           <= rd_val;
          rvalid_q[win_q]   <= 1'b1;
        end
      end
      if (pick_vld) begin
        state_q  <= ACCESS;
        win_q    <= pick;
        we_q     <= pick_we;
        rf_sel_q <= pick_addr;
        rf_in_q  <= pick_wdata;
        rf_en_q  <= pick_we & ~pick_bad;
        err_q    <= pick_bad;
        gnt_q    <= pick ? 2'b10 : 2'b01;
      end else begin
        state_q  <= IDLE;
        gnt_q    <= '0;
        rf_en_q  <= 1'b0;
        err_q    <= 1'b0;
      end
    end
  end

  assign GNT0    = gnt_q[0];
  assign GNT1    = gnt_q[1];
  assign RVALID0 = rvalid_q[0];
  assign RVALID1 = rvalid_q[1];
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign RF_SEL  = rf_sel_q;
  assign RF_IN   = rf_in_q;
  assign RF_EN   = rf_en_q;

endmodule

// File: tb/tb_reg_f_arb.sv
// Scoreboard bench for reg_f_arb: drivers queue issued transactions, a monitor
// predicts grants/responses from the arbitration rules and a transaction-level register model.
module tb_reg_f_arb;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned SIZE  = 11;
  localparam int unsigned SELW  = 4;
  localparam int unsigned ONES  = (1 << WIDTH) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [SELW-1:0]  ADDR0 = '0, ADDR1 = '0;
  logic [WIDTH-1:0] WDATA0 = '0, WDATA1 = '0;
  logic             GNT0, GNT1, RVALID0, RVALID1, ERR, RF_EN;
  logic [WIDTH-1:0] RDATA, RF_IN, RF_OUT;
  logic [SELW-1:0]  RF_SEL;

  reg_f_arb #(.WIDTH(WIDTH), .SIZE(SIZE), .SELW(SELW)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA(RDATA), .ERR(ERR), .RF_SEL(RF_SEL), .RF_IN(RF_IN), .RF_EN(RF_EN),
    .RF_OUT(RF_OUT)
  );

  always #5 CLK = ~CLK;

  // External single-port register file; seeded once while reset is held.
  logic [WIDTH-1:0] regs [16];
  logic [WIDTH-1:0] seed [16];
  bit               seeded = 1'b0;
  assign RF_OUT = regs[RF_SEL];
  always @(posedge CLK) begin
    if (RST && !seeded) begin
      for (int i = 0; i < 16; i++) regs[i] <= seed[i];
      seeded <= 1'b1;
    end else if (RF_EN) begin
      regs[RF_SEL] <= RF_IN;
    end
  end

  typedef struct { bit we; int unsigned addr; int unsigned wdata; } txn_t;
  typedef struct { int unsigned data; int unsigned due; } rsp_t;

  txn_t        iss0[$], iss1[$];
  rsp_t        rsp0[$], rsp1[$];
  int unsigned ref_mem [16];
  int          n_cmp = 0, n_err = 0;
  int unsigned cyc = 0;
  bit          last_m = 1'b1;

  logic [1:0] req_s = '0, gnt_s = '0;
  logic       rst_s = 1'b1;
  always @(posedge CLK) begin
    req_s <= {REQ1, REQ0};
    gnt_s <= {GNT1, GNT0};
    rst_s <= RST;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  task automatic monitor_step();
    logic [1:0]  elig, exp_g;
    txn_t        t;
    rsp_t        r;
    bit          bad;
    int unsigned ed;
    int          p;
    exp_g = '0;
    if (rst_s) begin
      rsp0.delete();
      rsp1.delete();
      last_m = 1'b1;
      chk("rst_rf_sel", 32'(RF_SEL), 0);
      chk("rst_rf_in", 32'(RF_IN), 0);
      chk("rst_rdata", 32'(RDATA), 0);
    end else begin
      elig  = req_s & ~gnt_s;
      exp_g = (elig == 2'b11) ? (last_m ? 2'b01 : 2'b10) : elig;
    end

    if (rsp0.size() > 0 && rsp0[0].due == cyc) begin
      r = rsp0.pop_front();
      chk("rvalid0", 32'(RVALID0), 1);
      chk("rdata0", 32'(RDATA), r.data);
    end else chk("rvalid0_idle", 32'(RVALID0), 0);
    if (rsp1.size() > 0 && rsp1[0].due == cyc) begin
      r = rsp1.pop_front();
      chk("rvalid1", 32'(RVALID1), 1);
      chk("rdata1", 32'(RDATA), r.data);
    end else chk("rvalid1_idle", 32'(RVALID1), 0);

    chk("gnt", 32'({GNT1, GNT0}), 32'(exp_g));
    if (exp_g != 2'b00) begin
      p      = exp_g[1] ? 1 : 0;
      last_m = exp_g[1];
      if ((p == 0 && iss0.size() == 0) || (p == 1 && iss1.size() == 0)) begin
        chk("grant_has_txn", 0, 1);
      end else begin
        t   = (p == 0) ? iss0.pop_front() : iss1.pop_front();
        bad = (t.addr > SIZE) || (t.we && t.addr <= 1);
        chk("err", 32'(ERR), 32'(bad));
        chk("rf_en", 32'(RF_EN), 32'(t.we && !bad));
        chk("rf_sel", 32'(RF_SEL), t.addr);
        chk("rf_in", 32'(RF_IN), t.wdata);
        if (t.we && !bad) ref_mem[t.addr] = t.wdata;
        if (!t.we) begin
          ed = (t.addr > SIZE || t.addr == 0) ? 0 : ((t.addr == 1) ? ONES : ref_mem[t.addr]);
          r  = '{ed, cyc + 1};
          if (p == 0) rsp0.push_back(r); else rsp1.push_back(r);
        end
      end
    end else begin
      chk("err_idle", 32'(ERR), 0);
      chk("rf_en_idle", 32'(RF_EN), 0);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    cyc++;
    monitor_step();
  end

  task automatic drive(input int p, input bit we, input int unsigned addr, input int unsigned wdata);
    txn_t t;
    t = '{we, addr, wdata};
    if (p == 0) begin
      iss0.push_back(t);
      WE0 = we; ADDR0 = SELW'(addr); WDATA0 = WIDTH'(wdata); REQ0 = 1'b1;
    end else begin
      iss1.push_back(t);
      WE1 = we; ADDR1 = SELW'(addr); WDATA1 = WIDTH'(wdata); REQ1 = 1'b1;
    end
  endtask

  task automatic wait_gnt(input int p);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if ((p == 0 && GNT0) || (p == 1 && GNT1)) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL gnt_timeout port %0d: got no grant, required one within 30 cycles", p);
    summary();
    $finish;
  endtask

  task automatic drop(input int p);
    if (p == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
  endtask

  task automatic txn(input int p, input bit we, input int unsigned addr, input int unsigned wdata);
    drive(p, we, addr, wdata);
    wait_gnt(p);
    @(posedge CLK); #1;
    drop(p);
  endtask

  task automatic run_port(input int p, input int n, input int unsigned gapmax);
    int unsigned gap;
    for (int i = 0; i < n; i++) begin
      drive(p, bit'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, ONES));
      wait_gnt(p);
      @(posedge CLK); #1;
      gap = $urandom_range(0, gapmax);
      if (gap != 0) begin
        drop(p);
        repeat (gap) @(posedge CLK);
        #1;
      end
    end
    drop(p);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      seed[i]    = WIDTH'($urandom_range(0, ONES));
      ref_mem[i] = 32'(seed[i]);
    end
    seed[0] = '0; ref_mem[0] = 0;
    seed[1] = '1; ref_mem[1] = ONES;

    // REQ0 held through reset; first grant one cycle after RST falls
    #1;
    drive(0, 1'b0, 3, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    wait_gnt(0);
    @(posedge CLK); #1;
    drop(0);

    txn(0, 1'b1, 5, 5);
    txn(1, 1'b0, 5, 0);

    fork
      run_port(0, 6, 0);
      run_port(1, 6, 0);
    join
    run_port(0, 3, 0);

    txn(0, 1'b1, 1, 0);
    txn(1, 1'b0, 1, 0);
    txn(0, 1'b0, 0, 0);
    txn(1, 1'b1, 2, 3);

    txn(0, 1'b0, 13, 0);
    txn(0, 1'b1, 15, 6);
    txn(1, 1'b0, 11, 0);

    // Reset lands on the edge closing port 1's read
    drive(1, 1'b0, 5, 0);
    wait_gnt(1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    drop(1);
    drive(0, 1'b0, 7, 0);
    drive(1, 1'b0, 4, 0);
    fork
      begin wait_gnt(0); @(posedge CLK); #1; drop(0); end
      begin wait_gnt(1); @(posedge CLK); #1; drop(1); end
    join

    fork
      run_port(0, 40, 2);
      run_port(1, 40, 2);
    join

    repeat (4) @(posedge CLK);
    #1;
    chk("issue_q_drained", 32'(iss0.size() + iss1.size()), 0);
    chk("rsp_q_drained", 32'(rsp0.size() + rsp1.size()), 0);
    summary();
    $finish;
  end
endmodule
